// File: rtl/riscv_defs.sv
// rtl/riscv_defs.sv - shared RV32I constants, fetch FSM states and PC helpers
package riscv_defs;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Modulo-2^32 increment; the top word wraps to zero silently.
  function automatic logic [31:0] pc_inc(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - one-entry buffer catching a fetch that completes under stall
module fetch_skid_buf
  import riscv_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        load,
  input  logic        drain,
  input  logic [31:0] load_inst,
  input  logic [31:0] load_pc,
  output logic        buf_valid,
  output logic [31:0] buf_inst,
  output logic [31:0] buf_pc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_inst  <= NOP_INST;
      buf_pc    <= DEFAULT_RESET_PC;
    end else if (flush) begin
      buf_valid <= 1'b0;
      buf_inst  <= NOP_INST;
    end else if (load) begin
      buf_valid <= 1'b1;
      buf_inst  <= load_inst;
      buf_pc    <= load_pc;
    end else if (drain) begin
      buf_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I instruction fetch: PC, imem request and IF/ID register
module fetch_stage
  import riscv_defs::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4
);

  logic [31:0]  pc;
  fetch_state_t state;

  logic        buf_valid;
  logic [31:0] buf_inst;
  logic [31:0] buf_pc;
  logic        buf_load;
  logic        buf_drain;

  // Request and address come straight from state registers, never from stall/redirect.
  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;

  assign buf_load  = (state == FETCH) && imem_ready && stall && !redirect;
  assign buf_drain = (state == HOLD) && !stall && !redirect;

  fetch_skid_buf u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .load      (buf_load),
    .drain     (buf_drain),
    .load_inst (imem_rdata),
    .load_pc   (pc),
    .buf_valid (buf_valid),
    .buf_inst  (buf_inst),
    .buf_pc    (buf_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      state       <= FETCH;
      if_valid    <= 1'b0;
      if_inst     <= NOP_INST;
      if_pc       <= RESET_PC;
      if_pc_plus4 <= pc_inc(RESET_PC);
    end else if (redirect) begin
      // Flush wins over stall and over any fetch completing this cycle.
      pc       <= word_align(redirect_pc);
      state    <= FETCH;
      if_valid <= 1'b0;
      if_inst  <= NOP_INST;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ready) begin
            pc <= pc_inc(pc);
            if (stall) begin
              state <= HOLD;
            end else begin
              if_valid    <= 1'b1;
              if_inst     <= imem_rdata;
              if_pc       <= pc;
              if_pc_plus4 <= pc_inc(pc);
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            state       <= FETCH;
            if_valid    <= buf_valid;
            if_inst     <= buf_inst;
            if_pc       <= buf_pc;
            if_pc_plus4 <= pc_inc(buf_pc);
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed and randomized check of fetch_stage against a queue model
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_valid    (if_valid),
    .if_inst     (if_inst),
    .if_pc       (if_pc),
    .if_pc_plus4 (if_pc_plus4)
  );

  // Model: next PC, a queue of fetched-but-undelivered words, and the decode-side slot.
  logic [31:0] m_pc;
  logic [31:0] q_inst[$];
  logic [31:0] q_pc[$];
  logic        m_valid;
  logic [31:0] m_inst;
  logic [31:0] m_ipc;

  task automatic model_update(input logic rdy, input logic st, input logic rd,
                              input logic [31:0] rp, input logic rs);
    if (rs) begin
      m_pc = 32'h0; q_inst.delete(); q_pc.delete();
      m_valid = 1'b0; m_inst = 32'h13; m_ipc = 32'h0;
    end else if (rd) begin
      m_pc = rp & 32'hFFFF_FFFC; q_inst.delete(); q_pc.delete();
      m_valid = 1'b0; m_inst = 32'h13;
    end else if (q_inst.size() != 0) begin
      if (!st) begin
        m_inst = q_inst.pop_front(); m_ipc = q_pc.pop_front(); m_valid = 1'b1;
      end
    end else if (rdy) begin
      if (st) begin
        q_inst.push_back(mem_word(m_pc)); q_pc.push_back(m_pc);
      end else begin
        m_inst = mem_word(m_pc); m_ipc = m_pc; m_valid = 1'b1;
      end
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic compare_all();
    chk("imem_req", {31'b0, imem_req}, {31'b0, q_inst.size() == 0});
    chk("imem_addr", imem_addr, m_pc);
    chk("if_valid", {31'b0, if_valid}, {31'b0, m_valid});
    chk("if_inst", if_inst, m_inst);
    chk("if_pc", if_pc, m_ipc);
    chk("if_pc_plus4", if_pc_plus4, m_ipc + 32'd4);
  endtask

  task automatic step(input logic rdy, input logic st, input logic rd,
                      input logic [31:0] rp, input logic rs);
    imem_ready = rdy; stall = st; redirect = rd; redirect_pc = rp; rst = rs;
    @(posedge clk);
    model_update(rdy, st, rd, rp, rs);
    #1;
    compare_all();
  endtask

  initial begin
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("lit_reset_valid", {31'b0, if_valid}, 32'h0);
    chk("lit_reset_inst", if_inst, 32'h0000_0013);
    chk("lit_reset_pc4", if_pc_plus4, 32'h4);
    chk("lit_reset_req", {31'b0, imem_req}, 32'h1);

    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("lit_first_valid", {31'b0, if_valid}, 32'h1);
    chk("lit_first_pc", if_pc, 32'h0);
    chk("lit_first_addr", imem_addr, 32'h4);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("lit_second_pc", if_pc, 32'h4);
    chk("lit_second_pc4", if_pc_plus4, 32'h8);

    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("lit_wait_addr", imem_addr, 32'h8);
      chk("lit_wait_req", {31'b0, imem_req}, 32'h1);
      chk("lit_wait_pc", if_pc, 32'h4);
    end
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("lit_third_pc", if_pc, 32'h8);
    chk("lit_third_addr", imem_addr, 32'hC);

    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("lit_hold_req", {31'b0, imem_req}, 32'h0);
      chk("lit_hold_pc", if_pc, 32'h8);
    end
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("lit_drain_pc", if_pc, 32'hC);
    chk("lit_drain_req", {31'b0, imem_req}, 32'h1);
    chk("lit_drain_addr", imem_addr, 32'h10);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("lit_resume_pc", if_pc, 32'h10);

    step(1'b1, 1'b0, 1'b1, 32'h0000_0103, 1'b0);
    chk("lit_redir_valid", {31'b0, if_valid}, 32'h0);
    chk("lit_redir_inst", if_inst, 32'h0000_0013);
    chk("lit_redir_addr", imem_addr, 32'h0000_0100);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("lit_redir_newpc", if_pc, 32'h0000_0100);

    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h0000_0200, 1'b0);
    chk("lit_hold_redir_valid", {31'b0, if_valid}, 32'h0);
    chk("lit_hold_redir_addr", imem_addr, 32'h0000_0200);
    chk("lit_hold_redir_req", {31'b0, imem_req}, 32'h1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("lit_hold_redir_pc", if_pc, 32'h0000_0200);

    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
    chk("lit_top_addr", imem_addr, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("lit_wrap_addr", imem_addr, 32'h0);
    chk("lit_wrap_pc4", if_pc_plus4, 32'h0);

    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("lit_rst_hold_valid", {31'b0, if_valid}, 32'h0);
    chk("lit_rst_hold_pc", if_pc, 32'h0);
    chk("lit_rst_hold_addr", imem_addr, 32'h0);
    chk("lit_rst_hold_req", {31'b0, imem_req}, 32'h1);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
           $urandom_range(0, 99) < 5, $urandom, $urandom_range(0, 199) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the RV32I core. It owns the program counter and issues word reads to instruction memory. It registers each fetched instruction with its PC into the IF/ID register, which feeds the decode stage (register file read and immediate generation). It supports decode stalls without losing an in-flight fetch, and redirects from branches and jumps resolved downstream.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INST, 32'h0000_0013, `addi x0,x0,0` presented when the output slot is empty.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request; held until accepted.
- imem_addr  out  32  byte address = pc; bits [1:0] are always 0.
- imem_ready  in  1  memory accepts the request; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  instruction word.
- stall  in  1  decode cannot accept; IF/ID outputs must hold.
- redirect  in  1  taken branch, JAL or JALR; flush and refetch.
- redirect_pc  in  32  new PC; bits [1:0] are forced to 0.
- if_valid  out  1  if_inst/if_pc hold a real instruction.
- if_inst  out  32  registered instruction to decode.
- if_pc  out  32  PC of if_inst.
- if_pc_plus4  out  32  if_pc + 4, for JAL/JALR link.

## Operation
- Internal state:
  - pc register.
  - One-entry skid buffer: buf_valid, buf_inst, buf_pc.
  - FSM with states FETCH and HOLD.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - Fetch completes when imem_ready=1.
  - stall=0 on completion: write if_inst/if_pc, set if_valid=1, pc<=pc+4.
  - stall=1 on completion: write the skid buffer, set pc<=pc+4, go to HOLD.
- HOLD:
  - imem_req=0.
  - When stall drops: buffer moves to the IF/ID outputs, buf_valid<=0, go to FETCH.
- stall=1 with no completion: IF/ID outputs hold exactly, including if_valid.
- redirect (highest priority, any state):
  - pc<=redirect_pc & ~3, if_valid<=0, if_inst<=NOP_INST, buf_valid<=0, go to FETCH.
  - A fetch completing in the same cycle is discarded.
  - The flush overrides stall.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- Reset values:
  - pc=RESET_PC, state=FETCH, buf_valid=0.
  - if_valid=0, if_inst=NOP_INST, if_pc=RESET_PC, if_pc_plus4=RESET_PC+4.
  - imem_req=1 from the first cycle after reset deasserts.

## Timing
- Latency: imem_ready in cycle n gives if_valid/if_inst in cycle n+1.
- Throughput is 1 instruction/cycle with imem_ready held high and stall=0.
- Redirect asserted in cycle n:
  - if_valid=0 in cycle n+1.
  - imem_addr=redirect_pc in cycle n+1.
  - First new instruction appears in cycle n+2 at the earliest.
- Stall leaves at most one buffered instruction; imem_req is low for every HOLD cycle.
- Leaving HOLD in cycle n: the buffered instruction appears in cycle n+1, and imem_req=1 in cycle n+1.
- rst asserted mid-fetch or in HOLD: all state takes its reset values on the next edge, and the outstanding memory response is ignored.
- imem_addr and imem_req are driven from registers only (no combinational path from stall/redirect); if_* are registered.

## Structure
- Shared package riscv_defs holds:
  - NOP_INST encoding.
  - Default RESET_PC.
  - FSM state constants FETCH=1'b0, HOLD=1'b1.
  - Opcode constants shared with decode.
- Sub-module fetch_skid_buf holds the one-entry buffer (load, drain, flush). The PC and FSM stay in fetch_stage.

## Test plan
- Reset, then imem_ready=1 and stall=0 for 4 cycles → imem_addr 0,4,8,C; if_valid rises one cycle after first ready; if_pc 0,4,8 in order; if_pc_plus4=if_pc+4.
- imem_ready low for 3 cycles at pc=8 → imem_req and imem_addr=8 held; if_* unchanged.
- stall=1 for 3 cycles during continuous ready → one instruction buffered (pc=C), imem_req=0, outputs hold pc=8; after stall drops, if_pc=C next cycle, then fetch resumes at 10.
- redirect=1, redirect_pc=32'h0000_0103, in the same cycle as a completing fetch → next cycle if_valid=0, if_inst=32'h0000_0013, imem_addr=32'h0000_0100; the fetched word never appears.
- redirect during HOLD with stall=1 → buffer discarded, if_valid=0 despite stall, next fetch at redirect_pc.
- pc=32'hFFFF_FFFC completes → next imem_addr=0; rst asserted in HOLD → all outputs at reset values next cycle.
